id_imm_seq: RTL and testbench

ID_IMM_SEQ -- requirements
Module: id_imm_seq

---
 rtl/id_imm_seq_pkg.sv | 65 ++++++
 rtl/id_imm_seq_imm_gen.sv | 28 ++
 rtl/id_imm_seq.sv | 128 ++++++++++++
 tb/tb_id_imm_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_imm_seq_pkg.sv
// Shared CPU decode definitions: RV32I opcodes, ImmSel codes, decode-buffer
// entry layout and the opcode-to-ImmSel decode helper.
// Optional feature macro: IMM_SEQ_ILLEGAL_CHK_EN (adds a stored illegal bit).
package id_imm_seq_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned IMM_SEL_W = 3;
    localparam int unsigned OPC_W     = 7;

    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;

    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_U    = 3'd5
    } imm_sel_e;

    // One decode-buffer slot: immediate is formed at push time.
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        imm_sel_e        sel;
`ifdef IMM_SEQ_ILLEGAL_CHK_EN
        logic            illegal;
`endif
    } dec_entry_t;

    // Opcode to immediate format; unrecognised opcodes (and OP) carry no immediate.
    function automatic imm_sel_e decode_imm_sel(input logic [OPC_W-1:0] opcode);
        imm_sel_e sel;
        sel = IMM_NONE;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM: sel = IMM_I;
            OPC_STORE:                sel = IMM_S;
            OPC_BRANCH:               sel = IMM_B;
            OPC_JAL:                  sel = IMM_J;
            OPC_LUI, OPC_AUIPC:       sel = IMM_U;
            default:                  sel = IMM_NONE;
        endcase
        return sel;
    endfunction

`ifdef IMM_SEQ_ILLEGAL_CHK_EN
    // Illegal: not a 32-bit encoding, or an opcode outside the known set.
    function automatic logic opcode_illegal(input logic [OPC_W-1:0] opcode);
        return (opcode[1:0] != 2'b11) ||
               ((decode_imm_sel(opcode) == IMM_NONE) && (opcode != OPC_OP));
    endfunction
`endif

endpackage

// File: rtl/id_imm_seq_imm_gen.sv
// RV32I immediate generator.
// Ports: inst_i   - instruction bits [31:7] (opcode not needed here)
//        imm_sel_i - immediate format selector
//        imm_o    - sign/zero-formed 32-bit immediate (0 for IMM_NONE)
module id_imm_seq_imm_gen
    import id_imm_seq_pkg::*;
(
    input  logic [31:7]     inst_i,
    input  imm_sel_e        imm_sel_i,
    output logic [XLEN-1:0] imm_o
);

    // Standard RV32I bit scatter per format; all signed formats extend bit 31.
    always_comb begin
        imm_o = '0;
        case (imm_sel_i)
            IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            IMM_U: imm_o = {inst_i[31:12], 12'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_imm_seq.sv
// Decode-stage immediate sequencer: a DEPTH-entry FIFO between fetch and
// execute that decodes ImmSel and forms the immediate as each instruction
// is accepted, then presents the head entry to execute.
// Ports: clk_i, rst_i (sync, active high)
//        in_valid_i/in_ready_o, inst_i, pc_i   - fetch side
//        flush_i                                - drop all buffered entries
//        out_valid_o/out_ready_i, imm_o, imm_sel_o, pc_o, illegal_o - execute side
// Optional feature macro: IMM_SEQ_ILLEGAL_CHK_EN (illegal_o tied 0 when undefined).
module id_imm_seq
    import id_imm_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [XLEN-1:0]      inst_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      imm_o,
    output logic [IMM_SEL_W-1:0] imm_sel_o,
    output logic [XLEN-1:0]      pc_o,
    output logic                 illegal_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    dec_entry_t       mem_q [DEPTH];
    dec_entry_t       push_entry;
    dec_entry_t       head_entry;
    imm_sel_e         push_sel;
    logic [XLEN-1:0]  push_imm;
    logic             push;
    logic             pop;

    // EMPTY / PARTIAL / FULL are implied by count_q; no separate state register.
    assign in_ready_o  = (count_q < CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);

    assign push = in_valid_i  && in_ready_o  && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    // Opcode decode stays here; the generator only scatters bits.
    assign push_sel = decode_imm_sel(inst_i[6:0]);

    id_imm_seq_imm_gen u_imm_gen (
        .inst_i    (inst_i[31:7]),
        .imm_sel_i (push_sel),
        .imm_o     (push_imm)
    );

    // Entry captured on push.
    always_comb begin
        push_entry     = '0;
        push_entry.imm = push_imm;
        push_entry.pc  = pc_i;
        push_entry.sel = push_sel;
`ifdef IMM_SEQ_ILLEGAL_CHK_EN
        push_entry.illegal = opcode_illegal(inst_i[6:0]);
`endif
    end

    // Pointer/count next state; flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            case ({push, pop})
                2'b10:   count_d = CNT_W'(count_q + 1'b1);
                2'b01:   count_d = CNT_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset overrides flush and any in-flight transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // Head outputs are forced to zero whenever no entry is valid.
    always_comb begin
        head_entry = mem_q[rd_ptr_q];
        imm_o      = '0;
        imm_sel_o  = '0;
        pc_o       = '0;
        illegal_o  = 1'b0;
        if (out_valid_o) begin
            imm_o     = head_entry.imm;
            imm_sel_o = IMM_SEL_W'(head_entry.sel);
            pc_o      = head_entry.pc;
`ifdef IMM_SEQ_ILLEGAL_CHK_EN
            illegal_o = head_entry.illegal;
`endif
        end
    end

endmodule

// File: tb/tb_id_imm_seq.sv
// Self-checking bench for id_imm_seq: constant vector table, directed
// multi-cycle sequences, then randomized traffic against a queue model.
module tb_id_imm_seq;
    import id_imm_seq_pkg::*;

    localparam int unsigned DEPTH = 2;
`ifdef IMM_SEQ_ILLEGAL_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready, ill;
    logic [31:0] inst, pc, imm, pc_out;
    logic [2:0]  sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_imm_seq #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_i      (inst),
        .pc_i        (pc),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .imm_o       (imm),
        .imm_sel_o   (sel),
        .pc_o        (pc_out),
        .illegal_o   (ill)
    );

    typedef struct {
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } ref_t;

    ref_t mq[$];

    // Reference decode written from the RV32I immediate definitions.
    function automatic ref_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
        ref_t        r;
        logic [6:0]  op;
        logic [31:0] sx;
        op    = ins[6:0];
        r.pc  = p;
        r.imm = 32'h0;
        r.sel = 3'(IMM_NONE);
        sx    = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        if (op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111}) begin
            r.sel = 3'(IMM_I);
            r.imm = 32'($signed(ins) >>> 20);
        end else if (op == 7'b0100011) begin
            r.sel = 3'(IMM_S);
            r.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | 32'(ins[11:7]);
        end else if (op == 7'b1100011) begin
            r.sel = 3'(IMM_B);
            r.imm = (sx & 32'hFFFF_F000) | (32'(ins[7]) << 11) |
                    (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        end else if (op == 7'b1101111) begin
            r.sel = 3'(IMM_J);
            r.imm = (sx & 32'hFFF0_0000) | (32'(ins[19:12]) << 12) |
                    (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        end else if (op == 7'b0110111 || op == 7'b0010111) begin
            r.sel = 3'(IMM_U);
            r.imm = ins & 32'hFFFF_F000;
        end
        r.ill = CHK && ((ins[1:0] != 2'b11) ||
                        (r.sel == 3'(IMM_NONE) && op != 7'b0110011));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                        input logic [31:0] p, input logic fl, input logic ordy);
        bit rdy;
        rst       = r;
        in_valid  = iv;
        inst      = ins;
        pc        = p;
        flush     = fl;
        out_ready = ordy;
        if (r || fl) begin
            mq.delete();
        end else begin
            rdy = (mq.size() < DEPTH);
            if (mq.size() != 0 && ordy) void'(mq.pop_front());
            if (iv && rdy) mq.push_back(ref_decode(ins, p));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        bit v;
        v = (mq.size() != 0);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ready"}, 32'(in_ready), 32'(mq.size() < DEPTH));
        if (v) begin
            chk({tag, ".imm"}, imm,          mq[0].imm);
            chk({tag, ".sel"}, 32'(sel),     32'(mq[0].sel));
            chk({tag, ".pc"},  pc_out,       mq[0].pc);
            chk({tag, ".ill"}, 32'(ill),     32'(mq[0].ill));
        end else begin
            chk({tag, ".imm0"}, imm,         32'h0);
            chk({tag, ".sel0"}, 32'(sel),    32'h0);
            chk({tag, ".pc0"},  pc_out,      32'h0);
            chk({tag, ".ill0"}, 32'(ill),    32'h0);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [6:0]  ops[11];
        logic [31:0] rins;
        rst = 1'b1; in_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;

        vt[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'(IMM_I), 1'b0};
        vt[1]  = '{32'hFE112E23, 32'h104, 32'hFFFFFFFC, 3'(IMM_S), 1'b0};
        vt[2]  = '{32'h123452B7, 32'h108, 32'h12345000, 3'(IMM_U), 1'b0};
        vt[3]  = '{32'h00000033, 32'h10C, 32'h00000000, 3'(IMM_NONE), 1'b0};
        vt[4]  = '{32'h0000007F, 32'h110, 32'h00000000, 3'(IMM_NONE), CHK};
        vt[5]  = '{32'hFE000EE3, 32'h114, 32'hFFFFFFFC, 3'(IMM_B), 1'b0};
        vt[6]  = '{32'h0080006F, 32'h118, 32'h00000008, 3'(IMM_J), 1'b0};
        vt[7]  = '{32'h00008067, 32'h11C, 32'h00000000, 3'(IMM_I), 1'b0};
        vt[8]  = '{32'h7FF00013, 32'h120, 32'h000007FF, 3'(IMM_I), 1'b0};
        vt[9]  = '{32'h800000B7, 32'h124, 32'h80000000, 3'(IMM_U), 1'b0};
        vt[10] = '{32'h00000010, 32'h128, 32'h00000000, 3'(IMM_NONE), CHK};

        // Reset state
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rst.valid", 32'(out_valid), 32'h0);
        chk("rst.ready", 32'(in_ready),  32'h1);
        chk("rst.imm",   imm,            32'h0);
        chk("rst.pc",    pc_out,         32'h0);

        // Vector table: push one, expect it at the head next cycle, drain.
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, vt[i].inst, vt[i].pc, 1'b0, 1'b1);
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'h1);
            chk($sformatf("vec%0d.imm", i),   imm,            vt[i].imm);
            chk($sformatf("vec%0d.sel", i),   32'(sel),       32'(vt[i].sel));
            chk($sformatf("vec%0d.pc", i),    pc_out,         vt[i].pc);
            chk($sformatf("vec%0d.ill", i),   32'(ill),       32'(vt[i].ill));
            step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            chk($sformatf("vec%0d.drain", i), 32'(out_valid), 32'h0);
        end

        // Back-to-back pushes keep order
        step(1'b0, 1'b1, 32'hFE112E23, 32'h300, 1'b0, 1'b1);
        chk("b2b.imm0", imm,      32'hFFFFFFFC);
        chk("b2b.sel0", 32'(sel), 32'(IMM_S));
        step(1'b0, 1'b1, 32'h123452B7, 32'h304, 1'b0, 1'b1);
        chk("b2b.imm1", imm,      32'h12345000);
        chk("b2b.sel1", 32'(sel), 32'(IMM_U));
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("b2b.empty", 32'(out_valid), 32'h0);

        // Backpressure: third push held until space frees
        step(1'b0, 1'b1, 32'hFFF00093, 32'h200, 1'b0, 1'b0);
        chk("bp.ready1", 32'(in_ready), 32'h1);
        step(1'b0, 1'b1, 32'h00100093, 32'h204, 1'b0, 1'b0);
        chk("bp.ready2", 32'(in_ready), 32'h0);
        chk("bp.head0",  pc_out,        32'h200);
        step(1'b0, 1'b1, 32'h00200093, 32'h208, 1'b0, 1'b0);
        chk("bp.held",   32'(in_ready), 32'h0);
        chk("bp.stable", pc_out,        32'h200);
        chk("bp.stimm",  imm,           32'hFFFFFFFF);
        step(1'b0, 1'b1, 32'h00200093, 32'h208, 1'b0, 1'b1);
        chk("bp.head1",  pc_out,        32'h204);
        chk("bp.imm1",   imm,           32'h1);
        step(1'b0, 1'b1, 32'h00200093, 32'h208, 1'b0, 1'b1);
        chk("bp.head2",  pc_out,        32'h208);
        chk("bp.imm2",   imm,           32'h2);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("bp.empty",  32'(out_valid), 32'h0);

        // Flush while full with a push offered
        step(1'b0, 1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        chk("fl.full",  32'(in_ready),  32'h0);
        step(1'b0, 1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1);
        chk("fl.valid", 32'(out_valid), 32'h0);
        chk("fl.ready", 32'(in_ready),  32'h1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        chk("fl.gone",  32'(out_valid), 32'h0);

        // Reset mid-pop with one entry and a push offered
        step(1'b0, 1'b1, 32'hFFF00093, 32'h500, 1'b0, 1'b0);
        chk("rp.valid1", 32'(out_valid), 32'h1);
        step(1'b1, 1'b1, 32'h00100093, 32'h504, 1'b0, 1'b1);
        chk("rp.valid",  32'(out_valid), 32'h0);
        chk("rp.imm",    imm,            32'h0);
        chk("rp.ready",  32'(in_ready),  32'h1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("rp.after",  32'(out_valid), 32'h0);

        // Randomized traffic against the queue model
        ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
        for (int n = 0; n < 3000; n++) begin
            rins = $urandom;
            if ($urandom_range(0, 3) != 0) rins[6:0] = ops[$urandom_range(0, 10)];
            step(1'b0 || ($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 9) < 7),
                 rins,
                 $urandom,
                 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 9) < 6));
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
